// File: rtl/z80_bus_pkg.sv
// Shared definitions for the z80 bus responder: FSM state encoding,
// I/O read default and request-type encodings.
package z80_bus_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAITING = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;

  localparam logic [7:0] IO_RD_DEFAULT = 8'hFF;
  localparam int         WAIT_CNT_W    = 5;

  typedef enum logic [1:0] {MEM_RD, MEM_WR, IO_RD, IO_WR} req_kind_e;

  typedef struct packed {
    req_kind_e   kind;
    logic        m1;
    logic [15:0] addr;
    logic [7:0]  dout;
  } bus_req_t;

  function automatic logic req_is_mem(input req_kind_e kind);
    return (kind == MEM_RD) || (kind == MEM_WR);
  endfunction

endpackage

// File: rtl/z80_wait_gen.sv
// Load/decrement wait-state counter. WAIT is high while the count is non-zero;
// done pulses combinationally in the cycle whose edge completes the access.
module z80_wait_gen #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             wait_o,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    done  = 1'b0;
    if (load) begin
      cnt_d = load_val;
      done  = (load_val == '0);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
      done  = (cnt_q == CNT_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign wait_o = (cnt_q != '0);

endmodule

// File: rtl/z80_bus_mem.sv
// Memory and I/O responder for the cpu_z80 bus with programmable WAIT insertion.
// Optional Z80_BUS_MEM_M1_WAIT_EN adds one wait state to opcode fetches.
module z80_bus_mem
  import z80_bus_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 0,
  parameter int IO_PORTS    = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [15:0]           ADDR,
  input  logic [7:0]            DO,
  input  logic                  WR,
  input  logic                  MREQ,
  input  logic                  IORQ,
  input  logic                  M1,
  output logic [7:0]            RD_DATA,
  output logic                  WAIT,
  output logic [8*IO_PORTS-1:0] IO_OUT,
  output logic [IO_PORTS-1:0]   IO_STROBE,
  output logic [15:0]           FETCH_CNT,
  input  logic                  LD_EN,
  input  logic [ADDR_W-1:0]     LD_ADDR,
  input  logic [7:0]            LD_DATA
);

  localparam int IO_IDX_W = (IO_PORTS > 1) ? $clog2(IO_PORTS) : 1;

  logic [1:0]                 state_q, state_d;
  logic                       mreq_prev_q, iorq_prev_q;
  bus_req_t                   req_q, req_d, live_req, cur_req;
  logic [7:0]                 rd_data_q, rd_data_d;
  logic [IO_PORTS-1:0][7:0]   io_out_q, io_out_d;
  logic [IO_PORTS-1:0]        io_strobe_q, io_strobe_d;
  logic [15:0]                fetch_cnt_q, fetch_cnt_d;
  logic [7:0]                 mem_q [2**ADDR_W];

  logic                  mreq_rise, iorq_rise, start, done, mem_we;
  logic [WAIT_CNT_W-1:0] load_val;
  logic [ADDR_W-1:0]     mem_idx;
  logic [IO_IDX_W-1:0]   io_idx;
  logic                  unused_addr;

  z80_wait_gen #(.CNT_W(WAIT_CNT_W)) u_wait (
    .clk      (CLK),
    .rst      (RESET),
    .load     (start),
    .load_val (load_val),
    .wait_o   (WAIT),
    .done     (done)
  );

  always_comb begin
    mreq_rise     = MREQ & ~mreq_prev_q;
    iorq_rise     = IORQ & ~iorq_prev_q;
    // MREQ wins a simultaneous rise; the I/O request is dropped
    live_req.kind = mreq_rise ? (WR ? MEM_WR : MEM_RD) : (WR ? IO_WR : IO_RD);
    live_req.m1   = M1;
    live_req.addr = ADDR;
    live_req.dout = DO;
    start         = (state_q == ST_IDLE) && (mreq_rise || iorq_rise);
    // A zero-wait access completes on the capture edge, so it uses the live bus
    cur_req       = start ? live_req : req_q;
    req_d         = cur_req;
    load_val      = WAIT_CNT_W'(WAIT_STATES);
`ifdef Z80_BUS_MEM_M1_WAIT_EN
    if (live_req.m1 && req_is_mem(live_req.kind)) load_val = load_val + 1'b1;
`endif
    mem_idx       = cur_req.addr[ADDR_W-1:0];
    io_idx        = IO_IDX_W'(cur_req.addr & 16'(IO_PORTS - 1));
  end

  always_comb begin
    rd_data_d   = rd_data_q;
    io_out_d    = io_out_q;
    io_strobe_d = '0;
    fetch_cnt_d = fetch_cnt_q;
    mem_we      = 1'b0;
    if (done) begin
      case (cur_req.kind)
        MEM_RD: begin
          rd_data_d = mem_q[mem_idx];
          if (cur_req.m1 && fetch_cnt_q != 16'hFFFF) fetch_cnt_d = fetch_cnt_q + 16'd1;
        end
        MEM_WR: mem_we = ~RESET;
        IO_RD:  rd_data_d = IO_RD_DEFAULT;
        IO_WR: begin
          io_out_d[io_idx]    = cur_req.dout;
          io_strobe_d[io_idx] = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = done ? ST_HOLD : ST_WAITING;
      ST_WAITING: if (done) state_d = ST_HOLD;
      ST_HOLD:    if (!MREQ && !IORQ) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      mreq_prev_q <= 1'b0;
      iorq_prev_q <= 1'b0;
      req_q       <= '0;
      rd_data_q   <= '0;
      io_out_q    <= '0;
      io_strobe_q <= '0;
      fetch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mreq_prev_q <= MREQ;
      iorq_prev_q <= IORQ;
      req_q       <= req_d;
      rd_data_q   <= rd_data_d;
      io_out_q    <= io_out_d;
      io_strobe_q <= io_strobe_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  // RAM is not reset; the host load port is ordered last so it wins collisions
  always_ff @(posedge CLK) begin
    if (mem_we) mem_q[mem_idx] <= cur_req.dout;
    if (LD_EN)  mem_q[LD_ADDR] <= LD_DATA;
  end

  assign unused_addr = ^cur_req.addr;
  assign RD_DATA     = rd_data_q;
  assign IO_OUT      = io_out_q;
  assign IO_STROBE   = io_strobe_q;
  assign FETCH_CNT   = fetch_cnt_q;

endmodule
